mfp_ahb_btn_reader: RTL and testbench
=====================================

MFP_AHB_BTN_READER -- requirements
Module: mfp_ahb_btn_reader

Interface
REQ-001 Parameter DB_TICK, default 50000, meaning HCLK cycles between debounce samples (legal range 2..65535).
REQ-002 Parameter NBTN, default 5, meaning number of pushbutton inputs (1..8).
REQ-003 Parameter NSW, default 16, meaning number of slide-switch inputs (1..16).
REQ-004 HCLK  input  1  sole clock, all state on rising edge.
REQ-005 HRESET  input  1  synchronous, active-high reset.
REQ-006 HADDR  input  4  register select, address phase.
REQ-007 HTRANS  input  2  AHB-Lite transfer type, address phase.
REQ-008 HWDATA  input  32  write data, data phase.
REQ-009 HWRITE  input  1  1=write, 0=read, address phase.
REQ-010 HSEL  input  1  slave select, address phase.
REQ-011 HRDATA  output  32  read data, data phase.
REQ-012 BTN_IN  input  NBTN  raw asynchronous pushbuttons, active-high.
REQ-013 SW_IN  input  NSW  raw asynchronous switches.
REQ-014 IRQ  output  1  level interrupt, active-high.

Function
REQ-015 Register map on HADDR: 0x0 BTN_STATE (RO), 0x4 SW_STATE (RO), 0x8 EVENT (R, W1C), 0xC MASK (RW, bits [NBTN-1:0]); all other offsets read 0, writes ignored.
REQ-016 Transfer valid when HSEL=1 and HTRANS[1]=1; HADDR, HWRITE and validity registered in address phase.
REQ-017 Writes commit on the data-phase cycle using registered address and current HWDATA.
REQ-018 Reads: HRDATA registered, valid in the data-phase cycle after the address phase (one wait-free cycle latency); unused upper bits zero.
REQ-019 HRDATA holds its last value when no read is in data phase.
REQ-020 Each BTN_IN/SW_IN bit passes a two-flop synchronizer before any other use.
REQ-021 Prescaler counts 0..DB_TICK-1 and wraps, asserting a one-cycle tick at DB_TICK-1.
REQ-022 On each tick every synchronized bit is shifted into a 3-sample history; debounced bit takes the sample value only when all 3 samples agree, else holds.
REQ-023 Minimum debounced change latency: 2 sync cycles plus 3 ticks after input settles.
REQ-024 Debounced BTN rising edge (0->1) sets corresponding EVENT bit; falling edges do not.
REQ-025 EVENT bits sticky until cleared; writing 1 to bit clears it, 0 no effect.
REQ-026 Set and clear on the same cycle: set wins, bit stays 1.
REQ-027 IRQ = OR over (EVENT & MASK), registered, one cycle after EVENT/MASK change.
REQ-028 Back-to-back transfers on consecutive cycles shall each complete correctly, including read immediately after write to same register (returns new value).

Reset
REQ-029 On HRESET=1 at a clock edge: HRDATA=0, IRQ=0, EVENT=0, MASK=0, BTN_STATE=0, SW_STATE=0, sample histories=0, synchronizers=0, prescaler=0, registered address-phase signals cleared (no pending transfer).
REQ-030 Reset mid-transfer aborts it; no write commits and HRDATA=0 the following cycle.
REQ-031 After reset release, no EVENT bit sets from inputs already high until they debounce as rising edges from the reset value 0.

Configuration
REQ-032 Macro MFP_BTN_CLEAR_ON_READ_EN defined: a read of EVENT returns current bits and clears exactly those returned bits in the same data-phase cycle (REQ-026 set-wins still applies); W1C also remains.
REQ-033 Macro undefined: reads of EVENT are non-destructive; only W1C clears.

Verification
REQ-034 DB_TICK=4; reset, hold BTN_IN[0]=1 -> BTN_STATE reads 0x1 within 2+3*4+2 cycles, EVENT=0x1; MASK=0 -> IRQ stays 0.
REQ-035 BTN_IN[2] glitch high for 5 cycles (DB_TICK=4) -> BTN_STATE and EVENT stay 0.
REQ-036 EVENT=0x1, write MASK=0x1 -> IRQ=1 one cycle later; write 0x1 to EVENT -> EVENT=0, IRQ=0 next cycle.
REQ-037 Rising edge on BTN[1] same cycle as W1C 0x2 -> EVENT[1] reads 1.
REQ-038 SW_IN=0xA5C3 stable -> SW_STATE reads 0x0000A5C3; read 0x8 with MFP_BTN_CLEAR_ON_READ_EN and EVENT=0x3 -> returns 0x3, next read returns 0x0 (without macro, 0x3 again).
REQ-039 Write MASK then read MASK on next cycle -> new value; assert HRESET during data phase of a MASK write -> MASK=0.

Source files
------------

// File: rtl/mfp_ahb_btn_reader.sv
// AHB-Lite slave: debounced pushbuttons/switches, sticky button-press events and a maskable level IRQ.
// Optional macro MFP_BTN_CLEAR_ON_READ_EN: reading EVENT also clears the bits it returns.
module mfp_ahb_btn_reader #(
    parameter int DB_TICK = 50000,
    parameter int NBTN    = 5,
    parameter int NSW     = 16
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [3:0]      HADDR,
    input  logic [1:0]      HTRANS,
    input  logic [31:0]     HWDATA,
    input  logic            HWRITE,
    input  logic            HSEL,
    output logic [31:0]     HRDATA,
    input  logic [NBTN-1:0] BTN_IN,
    input  logic [NSW-1:0]  SW_IN,
    output logic            IRQ
);
    localparam int NIN = NBTN + NSW;
    localparam int CW  = $clog2(DB_TICK);

    localparam logic [3:0] ADDR_BTN   = 4'h0;
    localparam logic [3:0] ADDR_SW    = 4'h4;
    localparam logic [3:0] ADDR_EVENT = 4'h8;
    localparam logic [3:0] ADDR_MASK  = 4'hC;

    logic [NIN-1:0]  sync1, sync2, hist1, hist0, db, db_d, agree;
    logic [CW-1:0]   presc;
    logic            tick;
    logic            valid_q, write_q;
    logic [3:0]      addr_q;
    logic            addr_valid, wr_commit;
    logic [NBTN-1:0] evt, evt_d, mask, mask_d, clr_wr, clr_rd, rise;
    logic [31:0]     rdata_d;
    logic            unused;

    assign unused = ^{HTRANS[0], HWDATA[31:NBTN]};
    assign tick   = (presc == CW'(DB_TICK - 1));

    always_comb begin
        // NOTE: every signal driven here is given a default first so no path can infer a latch.
        agree = ~(hist1 ^ hist0) & ~(hist0 ^ sync2);
        db_d  = db;
        if (tick) db_d = (db & ~agree) | (sync2 & agree);
        rise = db_d[NBTN-1:0] & ~db[NBTN-1:0];

        wr_commit = valid_q && write_q;
        mask_d    = mask;
        clr_wr    = '0;
        if (wr_commit && addr_q == ADDR_MASK)  mask_d = HWDATA[NBTN-1:0];
        if (wr_commit && addr_q == ADDR_EVENT) clr_wr = HWDATA[NBTN-1:0];
`ifdef MFP_BTN_CLEAR_ON_READ_EN
        // HRDATA still holds exactly the bits this data phase is returning.
        clr_rd = (valid_q && !write_q && addr_q == ADDR_EVENT) ? HRDATA[NBTN-1:0] : '0;
`else
        clr_rd = '0;
`endif
        evt_d = (evt & ~(clr_wr | clr_rd)) | rise;

        // Read mux uses next-state values so a read directly behind a write/clear sees the result.
        addr_valid = HSEL && HTRANS[1];
        rdata_d    = '0;
        case (HADDR)
            ADDR_BTN:   rdata_d[NBTN-1:0] = db_d[NBTN-1:0];
            ADDR_SW:    rdata_d[NSW-1:0]  = db_d[NIN-1:NBTN];
            ADDR_EVENT: rdata_d[NBTN-1:0] = evt_d;
            ADDR_MASK:  rdata_d[NBTN-1:0] = mask_d;
            default:    ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1   <= '0;
            sync2   <= '0;
            hist1   <= '0;
            hist0   <= '0;
            db      <= '0;
            presc   <= '0;
            evt     <= '0;
            mask    <= '0;
            IRQ     <= 1'b0;
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            HRDATA  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync1 <= {SW_IN, BTN_IN};
            sync2 <= sync1;
            presc <= tick ? '0 : presc + CW'(1);
            if (tick) begin
                hist1 <= hist0;
                hist0 <= sync2;
            end
            db      <= db_d;
            evt     <= evt_d;
            mask    <= mask_d;
            IRQ     <= |(evt & mask);
            valid_q <= addr_valid;
            write_q <= HWRITE;
            addr_q  <= HADDR;
            if (addr_valid && !HWRITE) HRDATA <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_btn_reader.sv
// Self-checking bench for mfp_ahb_btn_reader: directed scenarios plus random traffic against a
// transaction-level reference model advanced once per clock edge.
module tb_mfp_ahb_btn_reader;
    localparam int DB_TICK = 4;
    localparam int NBTN    = 5;
    localparam int NSW     = 16;

    logic            HCLK   = 1'b0;
    logic            HRESET = 1'b1;
    logic [3:0]      HADDR  = '0;
    logic [1:0]      HTRANS = '0;
    logic [31:0]     HWDATA = '0;
    logic            HWRITE = 1'b0;
    logic            HSEL   = 1'b0;
    logic [31:0]     HRDATA;
    logic [NBTN-1:0] BTN_IN = '0;
    logic [NSW-1:0]  SW_IN  = '0;
    logic            IRQ;

    int          n_checks   = 0;
    int          n_fail     = 0;
    logic [31:0] next_wdata = '0;

    // Reference model state
    logic [NBTN-1:0] m_btn_db = '0, m_evt = '0, m_mask = '0;
    logic [NSW-1:0]  m_sw_db  = '0;
    logic [31:0]     m_rdata  = '0;
    logic            m_irq    = 1'b0;
    int              n_edge   = 0;
    logic            p_valid  = 1'b0, p_write = 1'b0;
    logic [3:0]      p_addr   = '0;
    logic [NBTN-1:0] btn_seen[$], btn_ticks[$];
    logic [NSW-1:0]  sw_seen[$],  sw_ticks[$];

    always #5 HCLK = ~HCLK;

    mfp_ahb_btn_reader #(.DB_TICK(DB_TICK), .NBTN(NBTN), .NSW(NSW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA), .BTN_IN(BTN_IN), .SW_IN(SW_IN), .IRQ(IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [3:0] addr);
        logic [31:0] v;
        v = '0;
        case (addr)
            4'h0: v[NBTN-1:0] = m_btn_db;
            4'h4: v[NSW-1:0]  = m_sw_db;
            4'h8: v[NBTN-1:0] = m_evt;
            4'hC: v[NBTN-1:0] = m_mask;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Advance the model by the clock edge that just occurred, using the inputs present at it.
    task automatic model_edge();
        logic [NBTN-1:0] btn_s, bt0, bt1, clr, rise;
        logic [NSW-1:0]  sw_s, st0, st1;
        if (HRESET) begin
            m_btn_db = '0; m_sw_db = '0; m_evt = '0; m_mask = '0;
            m_rdata = '0; m_irq = 1'b0; n_edge = 0;
            p_valid = 1'b0; p_write = 1'b0; p_addr = '0;
            btn_seen.delete(); sw_seen.delete(); btn_ticks.delete(); sw_ticks.delete();
            btn_ticks.push_back('0); btn_ticks.push_back('0);
            sw_ticks.push_back('0);  sw_ticks.push_back('0);
        end else begin
            m_irq = |(m_evt & m_mask);
            n_edge++;
            btn_s = (btn_seen.size() > 1) ? btn_seen[1] : '0;
            sw_s  = (sw_seen.size() > 1)  ? sw_seen[1]  : '0;
            btn_seen.push_front(BTN_IN);
            sw_seen.push_front(SW_IN);
            if (btn_seen.size() > 2) void'(btn_seen.pop_back());
            if (sw_seen.size() > 2)  void'(sw_seen.pop_back());
            rise = '0;
            if (n_edge % DB_TICK == 0) begin
                bt0 = btn_ticks[0]; bt1 = btn_ticks[1];
                st0 = sw_ticks[0];  st1 = sw_ticks[1];
                for (int i = 0; i < NBTN; i++)
                    if (bt0[i] == bt1[i] && bt1[i] == btn_s[i]) begin
                        rise[i]     = btn_s[i] & ~m_btn_db[i];
                        m_btn_db[i] = btn_s[i];
                    end
                for (int i = 0; i < NSW; i++)
                    if (st0[i] == st1[i] && st1[i] == sw_s[i]) m_sw_db[i] = sw_s[i];
                btn_ticks.push_front(btn_s); void'(btn_ticks.pop_back());
                sw_ticks.push_front(sw_s);   void'(sw_ticks.pop_back());
            end
            clr = '0;
            if (p_valid && p_write && p_addr == 4'hC) m_mask = HWDATA[NBTN-1:0];
            if (p_valid && p_write && p_addr == 4'h8) clr = HWDATA[NBTN-1:0];
`ifdef MFP_BTN_CLEAR_ON_READ_EN
            if (p_valid && !p_write && p_addr == 4'h8) clr = clr | m_rdata[NBTN-1:0];
`endif
            m_evt   = (m_evt & ~clr) | rise;
            p_valid = HSEL && HTRANS[1];
            p_write = HWRITE;
            p_addr  = HADDR;
            if (p_valid && !p_write) m_rdata = reg_value(p_addr);
        end
    endtask

    // One clock cycle: model the past edge, compare outputs, drive the next edge's bus inputs.
    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [3:0] addr, input logic [31:0] wd);
        @(negedge HCLK);
        model_edge();
        check("hrdata_vs_model", HRDATA, m_rdata);
        check("irq_vs_model", 32'(IRQ), 32'(m_irq));
        HWDATA     = next_wdata;
        next_wdata = wd;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        step(1'b1, 2'b10, 1'b0, addr, 32'h0);
        idle();
        data = HRDATA;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        step(1'b1, 2'b10, 1'b1, addr, data);
        idle();
    endtask

    initial begin
        logic [31:0] d, d2;
        int          idx, a;

        // Reset with BTN[0] already held high
        HRESET = 1'b1;
        BTN_IN = 5'b00001;
        repeat (3) idle();
        check("reset_hrdata", HRDATA, 32'h0);
        check("reset_irq", 32'(IRQ), 32'h0);
        HRESET = 1'b0;
        repeat (12) idle();
        rd(4'h0, d); check("btn_state_press", d, 32'h1);
        rd(4'h8, d); check("event_press", d, 32'h1);
        check("irq_masked_off", 32'(IRQ), 32'h0);

        // 5-cycle glitch on BTN[2] must be rejected
        BTN_IN[2] = 1'b1;
        repeat (5) idle();
        BTN_IN[2] = 1'b0;
        repeat (20) idle();
        rd(4'h0, d); check("btn_state_glitch", d, 32'h1);
        rd(4'h8, d); check("event_glitch", d, 32'h1);

        // Unmask -> IRQ one cycle after MASK commits; W1C drops it again
        wr(4'hC, 32'h1);
        idle(); check("irq_mask_commit", 32'(IRQ), 32'h0);
        idle(); check("irq_raised", 32'(IRQ), 32'h1);
        wr(4'h8, 32'h1);
        idle(); idle(); check("irq_cleared", 32'(IRQ), 32'h0);
        rd(4'h8, d); check("event_w1c", d, 32'h0);

        // BTN[1] rising edge lands on the same edge as a W1C of bit 1: set wins
        for (int i = 0; i < DB_TICK && (n_edge % DB_TICK) != 1; i++) idle();
        BTN_IN[1] = 1'b1;
        repeat (8) idle();
        step(1'b1, 2'b10, 1'b1, 4'h8, 32'h2);
        idle();
        rd(4'h8, d); check("set_wins_over_w1c", d, 32'h2);

        // Switches, then back-to-back EVENT reads
        SW_IN  = 16'hA5C3;
        BTN_IN = '0;
        repeat (20) idle();
        rd(4'h4, d); check("sw_state", d, 32'h0000A5C3);
        wr(4'h8, 32'h1F);
        BTN_IN = 5'b00011;
        repeat (20) idle();
        step(1'b1, 2'b10, 1'b0, 4'h8, 32'h0);
        step(1'b1, 2'b10, 1'b0, 4'h8, 32'h0);
        d = HRDATA;
        idle();
        d2 = HRDATA;
        check("event_read_first", d, 32'h3);
`ifdef MFP_BTN_CLEAR_ON_READ_EN
        check("event_read_second", d2, 32'h0);
`else
        check("event_read_second", d2, 32'h3);
`endif
        wr(4'h8, 32'h1F);
        rd(4'h8, d); check("event_w1c_all", d, 32'h0);

        // Write then read MASK back-to-back; reset during a MASK write data phase
        step(1'b1, 2'b10, 1'b1, 4'hC, 32'h1E);
        step(1'b1, 2'b10, 1'b0, 4'hC, 32'h0);
        idle();
        check("mask_read_after_write", HRDATA, 32'h1E);
        step(1'b1, 2'b10, 1'b1, 4'hC, 32'h1F);
        idle();
        HRESET = 1'b1;
        idle();
        check("hrdata_after_abort", HRDATA, 32'h0);
        HRESET = 1'b0;
        rd(4'hC, d); check("mask_after_abort", d, 32'h0);

        // Buttons high through reset only report once they debounce from 0
        rd(4'h8, d); check("event_right_after_reset", d, 32'h0);
        repeat (16) idle();
        rd(4'h8, d); check("event_after_redebounce", d, 32'h3);

        // Unmapped offsets, idle transfers and deselected writes
        rd(4'h2, d); check("unmapped_read_2", d, 32'h0);
        rd(4'hE, d); check("unmapped_read_e", d, 32'h0);
        wr(4'h6, 32'h1F);
        step(1'b1, 2'b00, 1'b1, 4'hC, 32'h1F);
        step(1'b0, 2'b10, 1'b1, 4'hC, 32'h1F);
        idle();
        rd(4'hC, d); check("mask_untouched", d, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                idx = $urandom_range(0, NBTN - 1);
                BTN_IN[idx] = ~BTN_IN[idx];
            end
            if ($urandom_range(0, 15) == 0) begin
                idx = $urandom_range(0, NSW - 1);
                SW_IN[idx] = ~SW_IN[idx];
            end
            HRESET = ($urandom_range(0, 299) == 0);
            a = $urandom_range(0, 4);
            step(1'($urandom), 2'($urandom), 1'($urandom),
                 (a == 4) ? 4'($urandom) : 4'(a * 4), $urandom);
        end
        HRESET = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
